// File: rtl/taylor_stage_2_datapath.sv
// taylor_stage_2_datapath
// Responder datapath for the Taylor stage-2 controller. Evaluates
// result = c0 + x*(c1 + x*c2) in Horner form on one shared signed
// fixed-point multiplier and one adder, steered by the controller's
// mul_ss/add_ss commands and their enables.
// Optional build macro: TAYLOR_DP_ROUND_EN -- when defined, the product
// rescale rounds half up (adds 1<<(FRAC-1) before the shift); otherwise
// the rescale is a plain arithmetic-shift truncation.
module taylor_stage_2_datapath #(
  parameter int W    = 16,
  parameter int FRAC = 12
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] c0_in,
  input  logic signed [W-1:0] c1_in,
  input  logic signed [W-1:0] c2_in,
  input  logic                mul_ss,
  input  logic                mul_ss_en,
  input  logic                add_ss,
  input  logic                add_ss_en,
  input  logic                output_ready,
  output logic signed [W-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                overflow
);

  // Product path is carried one bit wider than the full product so the
  // rounding offset can never wrap.
  localparam int PW = 2 * W + 1;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] x_reg, c0_reg, c1_reg, c2_reg;
  logic signed [W-1:0] p_reg, a_reg;
  logic                busy_reg;

  logic signed [W-1:0]   mul_a, mul_b;
  logic signed [PW-1:0]  prod_ext, prod_adj, scaled;
  logic signed [W-1:0]   mul_val;
  logic                  mul_sat;
  logic signed [W-1:0]   addend;
  logic signed [W:0]     sum;
  logic signed [W-1:0]   add_val;
  logic                  add_sat;
  logic                  mul_clamp, add_clamp, final_add;

  // Multiplier operand steering. On the start cycle the controller is still
  // idling with mul_ss=1, so the fresh operands bypass the latch.
  always_comb begin
    mul_a = x_reg;
    mul_b = a_reg;
    if (mul_ss) begin
      mul_b = c2_reg;
      if (start) begin
        mul_a = x_in;
        mul_b = c2_in;
      end
    end
  end

  assign prod_ext = PW'($signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b}));

`ifdef TAYLOR_DP_ROUND_EN
  localparam logic signed [PW-1:0] HALF_LSB = PW'(1) <<< (FRAC - 1);
  assign prod_adj = prod_ext + HALF_LSB;
`else
  assign prod_adj = prod_ext;
`endif

  assign scaled = prod_adj >>> FRAC;

  // Saturate when the bits above the W-bit result are not a pure sign run.
  assign mul_sat = !((&scaled[PW-1:W-1]) || !(|scaled[PW-1:W-1]));
  assign mul_val = mul_sat ? (scaled[PW-1] ? SAT_MIN : SAT_MAX) : scaled[W-1:0];

  // Adder: P plus C1 (inner Horner step) or C0 (final step), one guard bit.
  assign addend  = add_ss ? c0_reg : c1_reg;
  assign sum     = {p_reg[W-1], p_reg} + {addend[W-1], addend};
  assign add_sat = (sum[W] != sum[W-1]);
  assign add_val = add_sat ? (sum[W] ? SAT_MIN : SAT_MAX) : sum[W-1:0];

  assign mul_clamp = mul_ss_en && mul_sat;
  assign add_clamp = add_ss_en && add_sat;

  // The final add only produces a result while an operation is in flight.
  assign final_add = busy_reg && add_ss_en && add_ss && output_ready;

  // busy also covers the start cycle itself, so back-to-back operations
  // show no gap between them.
  assign busy = busy_reg || (start && rst_n);

  // Operand latch, P/A pipeline registers, result and status flags.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      x_reg        <= '0;
      c0_reg       <= '0;
      c1_reg       <= '0;
      c2_reg       <= '0;
      p_reg        <= '0;
      a_reg        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy_reg     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (start) begin
        x_reg    <= x_in;
        c0_reg   <= c0_in;
        c1_reg   <= c1_in;
        c2_reg   <= c2_in;
        busy_reg <= 1'b1;
      end else if (final_add) begin
        busy_reg <= 1'b0;
      end

      if (mul_ss_en) p_reg <= mul_val;
      if (add_ss_en) a_reg <= add_val;

      if (final_add) result <= add_val;
      result_valid <= final_add;

      // A new operation starts clean, except that its own first product
      // (computed this cycle from the bypassed operands) may already clamp.
      if (start) begin
        overflow <= mul_clamp;
      end else if (busy_reg && (mul_clamp || add_clamp)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
